// File: rtl/multiplicador_secuencial.sv
// Sequential signed fixed-point multiplier with symmetric saturation.
//
// Radix-2 shift-add core: operand magnitudes are multiplied one multiplier
// bit per clock, then the product is rescaled by 2^frac, saturated to
// +/-(2^largo - 1) and re-signed. The output format and saturation range
// match the downstream saturating adder, which can consume y unmodified.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   start  operation request, sampled only in idle
//   a, b   signed operands (largo+1 bits), captured when start is accepted
//   y      signed saturated product, registered, held until the next result
//   done   one-cycle pulse: y/ovf/unf are valid for the new result
//   busy   high whenever the FSM is not idle
//   ovf    positive saturation flag for the current y
//   unf    negative saturation flag for the current y
module multiplicador_secuencial #(
  parameter int unsigned largo = 20,
  parameter int unsigned frac  = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [largo:0] a,
  input  logic [largo:0] b,
  output logic [largo:0] y,
  output logic           done,
  output logic           busy,
  output logic           ovf,
  output logic           unf
);

  localparam int unsigned W  = largo + 1;
  localparam int unsigned AW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  localparam logic [W-1:0]  MaxSat = {1'b0, {largo{1'b1}}};
  localparam logic [W-1:0]  MinSat = {1'b1, {(largo - 1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] MaxMag = {{(AW - largo){1'b0}}, {largo{1'b1}}};

  typedef enum logic [1:0] {StIdle, StMult, StSat, StDone} state_e;

  state_e state_q, state_d;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] mcand_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [AW-1:0] prod_mag;
  logic          sat;

  // Magnitudes are kept unsigned at full width so -2^largo maps to 2^largo
  // without wrapping.
  assign a_mag    = a[largo] ? -a : a;
  assign b_mag    = b[largo] ? -b : b;
  // Truncating the magnitude rounds toward zero for both signs.
  assign prod_mag = acc_q >> frac;
  assign sat      = (prod_mag > MaxMag);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StMult;
      StMult: if (cnt_q == CW'(largo)) state_d = StSat;
      StSat:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      y        <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= {{W{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= a[largo] ^ b[largo];
          end
        end
        StMult: begin
          // LSB-first: the multiplicand is pre-shifted into place each step.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        StSat: begin
          if (sat) begin
            y   <= sign_q ? MinSat : MaxSat;
            ovf <= ~sign_q;
            unf <= sign_q;
          end else begin
            // A zero magnitude negates to zero, so no negative zero appears.
            y   <= sign_q ? -prod_mag[W-1:0] : prod_mag[W-1:0];
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
module tb_multiplicador_secuencial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] a;
  logic [20:0] b;
  logic [20:0] y;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        unf;

  int checks   = 0;
  int failures = 0;

  multiplicador_secuencial #(
    .largo(20),
    .frac (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .y    (y),
    .done (done),
    .busy (busy),
    .ovf  (ovf),
    .unf  (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, wait (bounded) for done, check the result.
  task automatic run_op(input string tag, input logic [20:0] av, input logic [20:0] bv,
                        input logic [20:0] ey, input logic eo, input logic eu);
    int edges;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 21'h0;
    b = 21'h0;
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, ".latency"}, edges, 32'd22);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".unf"}, 32'(unf), 32'(eu));
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int first_edge;
    int second_edge;
    logic [20:0] first_y;
    logic [20:0] second_y;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst.y", 32'(y), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.unf", 32'(unf), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic signed products
    run_op("p1.5x2",   21'h000600, 21'h000800, 21'h000C00, 1'b0, 1'b0);
    run_op("m1.5x2",   21'h1FFA00, 21'h000800, 21'h1FF400, 1'b0, 1'b0);
    run_op("m1.5xm2",  21'h1FFA00, 21'h1FF800, 21'h000C00, 1'b0, 1'b0);
    // Saturation
    run_op("maxsq",    21'h0FFFFF, 21'h0FFFFF, 21'h0FFFFF, 1'b1, 1'b0);
    run_op("minx2",    21'h100000, 21'h000800, 21'h100001, 1'b0, 1'b1);
    run_op("minx1",    21'h100000, 21'h000400, 21'h100001, 1'b0, 1'b1);
    // Truncation toward zero and zero results
    run_op("lsbxlsb",  21'h000001, 21'h000001, 21'h000000, 1'b0, 1'b0);
    run_op("mlsbxlsb", 21'h1FFFFF, 21'h000001, 21'h000000, 1'b0, 1'b0);
    run_op("zero",     21'h000000, 21'h1ABCDE, 21'h000000, 1'b0, 1'b0);
    run_op("mlsbx1.5", 21'h1FFFFF, 21'h000600, 21'h1FFFFF, 1'b0, 1'b0);
    run_op("mlsbx3",   21'h1FFFFF, 21'h000C00, 21'h1FFFFD, 1'b0, 1'b0);

    // start re-asserted at edges 5 and 22 must be ignored
    @(negedge clk);
    a = 21'h000600;
    b = 21'h000800;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ign.done22", 32'(done), 32'd1);
    check("ign.y", 32'(y), 32'h000C00);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("ign.extra_done", pulses, 32'd0);
    check("ign.busy", 32'(busy), 32'd0);

    // start held high: one result every 24 clocks, operands captured per op
    @(negedge clk);
    a = 21'h000600;
    b = 21'h000800;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 21'h1FFA00;
    first_edge  = -1;
    second_edge = -1;
    first_y     = '0;
    second_y    = '0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (done && first_edge < 0) begin
        first_edge = e;
        first_y    = y;
      end else if (done && second_edge < 0) begin
        second_edge = e;
        second_y    = y;
        start       = 1'b0;
      end
    end
    check("cont.first_edge", first_edge, 32'd22);
    check("cont.first_y", 32'(first_y), 32'h000C00);
    check("cont.second_edge", second_edge, 32'd46);
    check("cont.second_y", 32'(second_y), 32'h1FF400);
    check("cont.idle", 32'(busy), 32'd0);
    start = 1'b0;

    // Re-establish a nonzero y so the asynchronous clear is observable
    run_op("pre_rst", 21'h000600, 21'h000800, 21'h000C00, 1'b0, 1'b0);

    // Asynchronous reset mid-MULT
    @(negedge clk);
    a = 21'h0FFFFF;
    b = 21'h0FFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("arst.busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst.y", 32'(y), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.ovf", 32'(ovf), 32'd0);
    #2 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("arst.no_done", pulses, 32'd0);
    check("arst.idle", 32'(busy), 32'd0);
    run_op("post_rst", 21'h1FFA00, 21'h000800, 21'h1FF400, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
